// File: rtl/kmap_pkg.sv
// Shared types and limits for the kmap LUT sweep unit.
// Imported by the top and the bit-select sub-module.
package kmap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    localparam int N_MIN = 2;
    localparam int N_MAX = 6;

    function automatic bit n_ok(input int n);
        return (n >= N_MIN) && (n <= N_MAX);
    endfunction

endpackage

// File: rtl/kmap_lut.sv
// Combinational 2^N:1 bit select from a truth table.
// Returns tbl[idx].
module kmap_lut
    import kmap_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [(1<<N)-1:0] tbl,
    input  logic [N-1:0]      idx,
    output logic              y
);

    assign y = tbl[idx];

endmodule

// File: rtl/kmap_lut_sweep.sv
// Programmable N-input Boolean function with direct lookup
// and a self-timed exhaustive minterm sweep.
module kmap_lut_sweep
    import kmap_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_en,
    input  logic [(1<<N)-1:0] load_table,
    input  logic [N-1:0]   x,
    output logic           out,
    input  logic           start,
    output logic           busy,
    output logic           sweep_valid,
    output logic [N-1:0]   sweep_x,
    output logic           sweep_out,
    output logic           done,
    output logic [N:0]     ones_cnt
);

    localparam int M = 1 << N;
    localparam logic [N:0] LAST = (N+1)'(M - 1);
    localparam logic [N:0] ONE  = (N+1)'(1);

    if (!n_ok(N)) begin : g_bad_n
        $error("kmap_lut_sweep: N out of range");
    end

    logic [M-1:0] tbl;
    state_t       state;
    state_t       state_n;
    logic [N:0]   idx;
    logic [N:0]   idx_n;
    logic [N:0]   acc;
    logic [N:0]   acc_n;
    logic         valid_n;
    logic         done_n;
    logic         lut_x;
    logic         lut_s;
    logic         idle_ok;

    kmap_lut #(.N(N)) u_lut_x (
        .tbl (tbl),
        .idx (x),
        .y   (lut_x)
    );

    kmap_lut #(.N(N)) u_lut_s (
        .tbl (tbl),
        .idx (idx[N-1:0]),
        .y   (lut_s)
    );

    // busy lags state by one cycle, so the done cycle still blocks start/load
    assign idle_ok = (state == IDLE) && !busy;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        acc_n   = acc;
        valid_n = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (idle_ok && start) begin
                    state_n = SWEEP;
                    idx_n   = '0;
                    acc_n   = '0;
                end
            end
            SWEEP: begin
                valid_n = 1'b1;
                acc_n   = acc + {{N{1'b0}}, lut_s};
                idx_n   = idx + ONE;
                if (idx == LAST) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tbl         <= '0;
            idx         <= '0;
            acc         <= '0;
            out         <= 1'b0;
            busy        <= 1'b0;
            sweep_valid <= 1'b0;
            sweep_x     <= '0;
            sweep_out   <= 1'b0;
            done        <= 1'b0;
            ones_cnt    <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            acc         <= acc_n;
            if (idle_ok && load_en) begin
                tbl <= load_table;
            end
            out         <= lut_x;
            busy        <= (state != IDLE);
            sweep_valid <= valid_n;
            sweep_x     <= valid_n ? idx[N-1:0] : '0;
            sweep_out   <= valid_n & lut_s;
            done        <= done_n;
            if (done_n) begin
                ones_cnt <= acc;
            end
        end
    end

endmodule
